// File: rtl/wb_arb_rr_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // tmo_id is a fixed 3-bit field so N up to 8 fits without a port change.
  localparam int TMO_ID_W = 3;

  // Width of a master index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_rr_if.sv
// Bundled master-side and slave-side Wishbone signals of the arbiter.
// Master i occupies slice [i*W +: W] of each packed master vector.
interface wb_arb_rr_if #(
  parameter int N  = 2,
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int MW = DW / 8
);
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_rdata;
  logic [N*DW-1:0] m_wdata;
  logic [N*MW-1:0] m_wmsk;
  logic [N-1:0]    m_we;
  logic [N-1:0]    m_cyc;
  logic [N-1:0]    m_ack;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_rdata;
  logic [DW-1:0]   s_wdata;
  logic [MW-1:0]   s_wmsk;
  logic            s_we;
  logic            s_cyc;
  logic            s_ack;

  // Arbiter view: a slave to the masters, a master to the shared slave.
  modport slave (
    input  m_addr, m_wdata, m_wmsk, m_we, m_cyc, s_rdata, s_ack,
    output m_rdata, m_ack, s_addr, s_wdata, s_wmsk, s_we, s_cyc
  );

  // Environment view: the requesting masters plus the shared slave device.
  modport master (
    output m_addr, m_wdata, m_wmsk, m_we, m_cyc, s_rdata, s_ack,
    input  m_rdata, m_ack, s_addr, s_wdata, s_wmsk, s_we, s_cyc
  );

endinterface

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
module arb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    int c;
    logic [IW-1:0] ci;
    valid = |req;
    idx   = last;
    c     = 0;
    ci    = '0;
    for (int k = N; k >= 1; k--) begin
      c  = (int'(last) + k) % N;
      ci = IW'(c);
      if (req[ci]) idx = ci;
    end
  end

endmodule

// File: rtl/wb_arb_rr.sv
// N-master to 1-slave Wishbone classic arbiter with round-robin grant and
// a slave-side timeout that acks the stuck master with zero data.
//
//   state    | meaning
//   ST_IDLE  | no owner on the bus; pick the next requester after owner
//   ST_BUSY  | owner's cycle forwarded to the slave; timeout counter runs
//   ST_DRAIN | one dead cycle after ack/timeout so the slave sees idle
module wb_arb_rr
  import wb_arb_rr_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int MW = DW / 8,
  parameter int TW = 8
) (
  input  logic                clk,
  input  logic                rst,
  wb_arb_rr_if.slave          bus,
  output logic                tmo_stb,
  output logic [TMO_ID_W-1:0] tmo_id
);

  localparam int            IW       = idx_width(N);
  localparam logic [TW-1:0] CNT_TERM = {TW{1'b1}};

  arb_state_t          state;
  logic [IW-1:0]       owner;
  logic [TW-1:0]       cnt;
  logic [TMO_ID_W-1:0] tmo_id_q;

  logic                pick_valid;
  logic [IW-1:0]       pick_idx;

  logic [AW-1:0]       addr_a  [N];
  logic [DW-1:0]       wdata_a [N];
  logic [MW-1:0]       wmsk_a  [N];

  logic                busy;
  logic                own_cyc;
  logic                ack_ok;
  logic                tmo_hit;
  logic                abort;

  // Unpack the per-master buses and build the per-master return paths.
  for (genvar g = 0; g < N; g++) begin : g_mst
    assign addr_a[g]  = bus.m_addr[g*AW +: AW];
    assign wdata_a[g] = bus.m_wdata[g*DW +: DW];
    assign wmsk_a[g]  = bus.m_wmsk[g*MW +: MW];
    assign bus.m_ack[g] = (ack_ok | tmo_hit) & (owner == IW'(g));
    // Zero outside the ack cycle so masters' rdata can be OR-combined.
    assign bus.m_rdata[g*DW +: DW] = (ack_ok && owner == IW'(g)) ? bus.s_rdata : '0;
  end

  arb_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (bus.m_cyc),
    .last  (owner),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy    = (state == ST_BUSY);
  assign own_cyc = bus.m_cyc[owner];
  assign ack_ok  = busy & own_cyc & bus.s_ack;
  // A real ack on the terminal count beats the timeout.
  assign tmo_hit = busy & own_cyc & ~bus.s_ack & (cnt == CNT_TERM);
  assign abort   = busy & ~own_cyc;

  assign bus.s_cyc   = busy & own_cyc & ~tmo_hit;
  assign bus.s_addr  = addr_a[owner];
  assign bus.s_wdata = wdata_a[owner];
  assign bus.s_wmsk  = wmsk_a[owner];
  assign bus.s_we    = bus.m_we[owner];

  assign tmo_stb = tmo_hit;
  assign tmo_id  = tmo_hit ? TMO_ID_W'(owner) : tmo_id_q;

  // Grant FSM, owner register, timeout counter and held timeout id.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= IW'(N - 1);
      cnt      <= '0;
      tmo_id_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (ack_ok) begin
            state <= ST_DRAIN;
          end else if (tmo_hit) begin
            tmo_id_q <= TMO_ID_W'(owner);
            state    <= ST_DRAIN;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arb_rr.sv
// Scoreboard bench for wb_arb_rr with two masters and a 4-bit timeout.
module tb_wb_arb_rr;

  localparam int N  = 2;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TW = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmsk;
    logic          expect_ack;
    logic          tmo;
    logic [DW-1:0] rdata;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tmo_stb;
  logic [2:0] tmo_id;

  wb_arb_rr_if #(.N(N), .AW(AW), .DW(DW), .MW(MW)) bus ();

  wb_arb_rr #(.N(N), .AW(AW), .DW(DW), .MW(MW), .TW(TW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .tmo_stb (tmo_stb),
    .tmo_id  (tmo_id)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          slv_lat  = -1;
  int          run      = 0;
  logic [DW-1:0] rd_val = '0;
  logic        ack_seen   [N];
  logic        active     [N];
  logic        abort_flag [N];
  logic        prev_scyc  = 1'b0;
  txn_t        pend_q [N][$];
  txn_t        exp_q  [N][$];
  int          grant_log[$];
  int          ack_cyc_log[$];
  int          rise_log[$];

  // Slave model: acks once s_cyc has been high for slv_lat cycles.
  initial begin
    bus.s_ack   = 1'b0;
    bus.s_rdata = 32'h0BAD_F00D;
    forever begin
      @(posedge clk);
      #1;
      if (slv_lat > 0 && run == slv_lat) begin
        bus.s_ack   = 1'b1;
        bus.s_rdata = rd_val;
      end else begin
        bus.s_ack   = 1'b0;
        bus.s_rdata = 32'h0BAD_F00D;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.s_cyc) run++;
      else run = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic push_txn(input int m, input logic [AW-1:0] a, input logic we,
                          input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                          input logic ea, input logic tmo);
    txn_t t;
    t.addr = a; t.we = we; t.wdata = wd; t.wmsk = wm;
    t.expect_ack = ea; t.tmo = tmo;
    t.rdata = tmo ? '0 : rd_val;
    pend_q[m].push_back(t);
  endtask

  task automatic drive();
    txn_t t;
    for (int i = 0; i < N; i++) begin
      if (active[i] && (ack_seen[i] || abort_flag[i])) begin
        active[i] = 1'b0;
        bus.m_cyc[i] = 1'b0;
      end
      abort_flag[i] = 1'b0;
      if (!active[i] && pend_q[i].size() > 0) begin
        t = pend_q[i].pop_front();
        bus.m_addr[i*AW +: AW]  = t.addr;
        bus.m_wdata[i*DW +: DW] = t.wdata;
        bus.m_wmsk[i*MW +: MW]  = t.wmsk;
        bus.m_we[i]  = t.we;
        bus.m_cyc[i] = 1'b1;
        active[i]    = 1'b1;
        if (t.expect_ack) exp_q[i].push_back(t);
      end
    end
  endtask

  task automatic sample();
    txn_t e;
    logic [DW-1:0] rd;
    if (bus.s_cyc && !prev_scyc) rise_log.push_back(cyc);
    prev_scyc = bus.s_cyc;
    if ($countones(bus.m_ack) > 1) begin
      n_checks++; n_fail++;
      $display("FAIL multi_ack: got %b expected one-hot at cycle %0d", bus.m_ack, cyc);
    end
    for (int i = 0; i < N; i++) begin
      ack_seen[i] = bus.m_ack[i];
      rd = bus.m_rdata[i*DW +: DW];
      if (bus.m_ack[i]) begin
        grant_log.push_back(i);
        ack_cyc_log.push_back(cyc);
        n_checks++;
        if (exp_q[i].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: master %0d acked at cycle %0d, expected no ack", i, cyc);
        end else begin
          e = exp_q[i].pop_front();
          if (rd !== e.rdata) begin
            n_fail++;
            $display("FAIL ack_rdata m%0d: got %h expected %h", i, rd, e.rdata);
          end
          n_checks++;
          if (tmo_stb !== e.tmo) begin
            n_fail++;
            $display("FAIL ack_tmo_stb m%0d: got %b expected %b", i, tmo_stb, e.tmo);
          end
          n_checks++;
          if (e.tmo) begin
            if (tmo_id !== 3'(i) || bus.s_cyc !== 1'b0) begin
              n_fail++;
              $display("FAIL tmo_cycle m%0d: got id %0d s_cyc %b expected id %0d s_cyc 0",
                       i, tmo_id, bus.s_cyc, i);
            end
          end else begin
            if ({bus.s_addr, bus.s_we, bus.s_wdata, bus.s_wmsk} !== {e.addr, e.we, e.wdata, e.wmsk}) begin
              n_fail++;
              $display("FAIL slave_fields m%0d: got %h/%b/%h/%h expected %h/%b/%h/%h", i,
                       bus.s_addr, bus.s_we, bus.s_wdata, bus.s_wmsk, e.addr, e.we, e.wdata, e.wmsk);
            end
          end
        end
      end else begin
        n_checks++;
        if (rd !== '0) begin
          n_fail++;
          $display("FAIL rdata_isolation m%0d: got %h expected 0 at cycle %0d", i, rd, cyc);
        end
      end
    end
    if (bus.m_ack === '0) begin
      n_checks++;
      if (tmo_stb !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_tmo_stb: got %b expected 0 at cycle %0d", tmo_stb, cyc);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #2;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic run_acks(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && grant_log.size() < target; k++) step();
    ok = (grant_log.size() >= target);
  endtask

  task automatic run_rises(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && rise_log.size() < target; k++) step();
    ok = (rise_log.size() >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({bus.s_cyc, bus.m_ack, tmo_stb, tmo_id} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got s_cyc %b m_ack %b tmo_stb %b tmo_id %0d expected all 0",
               bus.s_cyc, bus.m_ack, tmo_stb, tmo_id);
    end
    rst = 1'b0;
    repeat (2) step();
    n_checks++;
    if (bus.s_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got s_cyc %b expected 0", bus.s_cyc);
    end
  endtask

  task automatic test_single();
    int t0, rb, ab;
    bit ok;
    rd_val = 32'h1111_2222;
    slv_lat = 2;
    rb = rise_log.size(); ab = ack_cyc_log.size();
    push_txn(0, 14'h0123, 1'b1, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b0);
    push_txn(0, 14'h0124, 1'b1, 32'h5A5A_5A5A, 4'h3, 1'b1, 1'b0);
    step();
    t0 = cyc;
    run_acks(ab + 2, 40, ok);
    n_checks++;
    if (!ok || rise_log.size() < rb + 2) begin
      n_fail++;
      $display("FAIL single_timeout: got %0d acks expected %0d", grant_log.size() - ab, 2);
      return;
    end
    n_checks++;
    if (rise_log[rb] !== t0 + 1) begin
      n_fail++; $display("FAIL single_scyc: got cycle %0d expected %0d", rise_log[rb], t0 + 1);
    end
    n_checks++;
    if (ack_cyc_log[ab] !== t0 + 3) begin
      n_fail++; $display("FAIL single_ack: got cycle %0d expected %0d", ack_cyc_log[ab], t0 + 3);
    end
    n_checks++;
    if (rise_log[rb+1] !== t0 + 6) begin
      n_fail++; $display("FAIL next_grant: got cycle %0d expected %0d", rise_log[rb+1], t0 + 6);
    end
    n_checks++;
    if (ack_cyc_log[ab+1] !== t0 + 8) begin
      n_fail++; $display("FAIL second_ack: got cycle %0d expected %0d", ack_cyc_log[ab+1], t0 + 8);
    end
  endtask

  task automatic test_read_isolation();
    int rb, ab;
    bit ok;
    rd_val = 32'hDEAD_BEEF;
    slv_lat = 3;
    rb = rise_log.size(); ab = ack_cyc_log.size();
    push_txn(1, 14'h3FFF, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    run_acks(ab + 1, 30, ok);
    n_checks++;
    if (!ok || rise_log.size() <= rb) begin
      n_fail++; $display("FAIL read_timeout: got %0d acks expected 1", grant_log.size() - ab);
      return;
    end
    n_checks++;
    if (grant_log[ab] !== 1 || ack_cyc_log[ab] - rise_log[rb] !== 3) begin
      n_fail++;
      $display("FAIL read_grant: got master %0d latency %0d expected master 1 latency 3",
               grant_log[ab], ack_cyc_log[ab] - rise_log[rb]);
    end
  endtask

  task automatic test_contention();
    int gb;
    bit ok;
    rd_val = 32'h0000_C0DE;
    slv_lat = 1;
    gb = grant_log.size();
    for (int k = 0; k < 3; k++) begin
      push_txn(0, 14'(16'h0100 + k), 1'b1, 32'h1000_0000 + k, 4'hF, 1'b1, 1'b0);
      push_txn(1, 14'(16'h0200 + k), 1'b0, 32'h2000_0000 + k, 4'h1, 1'b1, 1'b0);
    end
    run_acks(gb + 6, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL contention_timeout: got %0d acks expected 6", grant_log.size() - gb);
      return;
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (grant_log[gb+k] !== k % 2) begin
        n_fail++;
        $display("FAIL contention_order[%0d]: got master %0d expected %0d", k, grant_log[gb+k], k % 2);
      end
    end
  endtask

  task automatic test_timeout();
    int rb, gb;
    bit ok;
    rd_val = 32'h7777_8888;
    slv_lat = -1;
    rb = rise_log.size(); gb = grant_log.size();
    push_txn(1, 14'h0010, 1'b1, 32'hCAFE_0001, 4'hF, 1'b1, 1'b1);
    run_rises(rb + 1, 10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL tmo_grant_timeout: got no s_cyc expected grant to master 1");
      return;
    end
    push_txn(0, 14'h0020, 1'b1, 32'hCAFE_0002, 4'hC, 1'b1, 1'b0);
    run_acks(gb + 1, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL tmo_never_fired: got no ack expected timeout ack");
      return;
    end
    slv_lat = 2;
    n_checks++;
    if (grant_log[gb] !== 1 || ack_cyc_log[gb] - rise_log[rb] !== 15) begin
      n_fail++;
      $display("FAIL tmo_latency: got master %0d after %0d cycles expected master 1 after 15",
               grant_log[gb], ack_cyc_log[gb] - rise_log[rb]);
    end
    run_acks(gb + 2, 30, ok);
    n_checks++;
    if (!ok || grant_log[gb+1] !== 0) begin
      n_fail++; $display("FAIL tmo_next_grant: got %0d acks expected master 0 granted", grant_log.size() - gb);
    end
    n_checks++;
    if (tmo_id !== 3'd1) begin
      n_fail++; $display("FAIL tmo_id_hold: got %0d expected 1", tmo_id);
    end
  endtask

  task automatic test_ack_at_terminal();
    int rb, gb;
    bit ok;
    rd_val = 32'h1357_9BDF;
    slv_lat = 15;
    rb = rise_log.size(); gb = grant_log.size();
    push_txn(1, 14'h2222, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    run_acks(gb + 1, 40, ok);
    n_checks++;
    if (!ok || rise_log.size() <= rb) begin
      n_fail++; $display("FAIL term_timeout: got no ack expected one");
      return;
    end
    n_checks++;
    if (grant_log[gb] !== 1 || ack_cyc_log[gb] - rise_log[rb] !== 15) begin
      n_fail++;
      $display("FAIL term_latency: got master %0d after %0d cycles expected master 1 after 15",
               grant_log[gb], ack_cyc_log[gb] - rise_log[rb]);
    end
    n_checks++;
    if (tmo_id !== 3'd1) begin
      n_fail++; $display("FAIL term_tmo_id: got %0d expected 1", tmo_id);
    end
  endtask

  task automatic test_abort();
    int rb, gb, a;
    bit ok;
    rd_val = 32'h2468_ACE0;
    slv_lat = -1;
    rb = rise_log.size(); gb = grant_log.size();
    push_txn(0, 14'h0333, 1'b1, 32'hAB0A_AB0A, 4'hF, 1'b0, 1'b0);
    run_rises(rb + 1, 10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL abort_grant_timeout: got no s_cyc expected grant");
      return;
    end
    repeat (2) step();
    abort_flag[0] = 1'b1;
    push_txn(1, 14'h0444, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    step();
    a = cyc;
    slv_lat = 2;
    n_checks++;
    if (bus.s_cyc !== 1'b0 || bus.m_ack !== '0) begin
      n_fail++; $display("FAIL abort_cycle: got s_cyc %b m_ack %b expected 0 0", bus.s_cyc, bus.m_ack);
    end
    run_acks(gb + 1, 20, ok);
    n_checks++;
    if (!ok || rise_log.size() < rb + 2) begin
      n_fail++; $display("FAIL abort_next_timeout: got %0d acks expected 1", grant_log.size() - gb);
      return;
    end
    n_checks++;
    if (rise_log[rb+1] !== a + 2 || grant_log[gb] !== 1) begin
      n_fail++;
      $display("FAIL abort_to_idle: got grant at cycle %0d to m%0d expected cycle %0d to m1",
               rise_log[rb+1], grant_log[gb], a + 2);
    end
  endtask

  task automatic test_reset_mid();
    int rb, gb;
    bit ok;
    rd_val = 32'h0F0F_F0F0;
    slv_lat = -1;
    rb = rise_log.size();
    push_txn(0, 14'h0555, 1'b1, 32'h5555_0000, 4'hF, 1'b0, 1'b0);
    run_rises(rb + 1, 10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rst_grant_timeout: got no s_cyc expected grant");
      return;
    end
    repeat (2) step();
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.s_cyc !== 1'b0 || bus.m_ack !== '0) begin
      n_fail++; $display("FAIL rst_mid_busy: got s_cyc %b m_ack %b expected 0 0", bus.s_cyc, bus.m_ack);
    end
    bus.m_cyc = '0;
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0; ack_seen[i] = 1'b0;
      exp_q[i].delete(); pend_q[i].delete();
    end
    rst = 1'b0;
    slv_lat = 1;
    gb = grant_log.size();
    push_txn(0, 14'h0666, 1'b1, 32'h6666_0000, 4'hF, 1'b1, 1'b0);
    push_txn(1, 14'h0777, 1'b1, 32'h7777_0000, 4'hF, 1'b1, 1'b0);
    run_acks(gb + 2, 30, ok);
    n_checks++;
    if (!ok || grant_log[gb] !== 0 || grant_log[gb+1] !== 1) begin
      n_fail++; $display("FAIL rst_priority: got %0d acks, order wrong, expected master 0 then 1",
                         grant_log.size() - gb);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.m_addr = '0; bus.m_wdata = '0; bus.m_wmsk = '0;
    bus.m_we = '0; bus.m_cyc = '0;
    for (int i = 0; i < N; i++) begin
      ack_seen[i] = 1'b0; active[i] = 1'b0; abort_flag[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_read_isolation();
    test_contention();
    test_timeout();
    test_ack_at_terminal();
    test_abort();
    test_reset_mid();
    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (exp_q[i].size() != 0) begin
        n_fail++; $display("FAIL leftover_expect m%0d: got %0d pending expected 0", i, exp_q[i].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
